// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron scheduler: fixed-point word
// format (bit16 sign, Q8.8 magnitude), reset state constants and FSM encoding.
package izh_pkg;

  localparam int DP_W = 17;

  localparam logic [DP_W-1:0] DP_RESET_V     = 17'h14100;  // -65.0
  localparam logic [DP_W-1:0] DP_RESET_U     = 17'h10D00;  // -13.0
  localparam logic [DP_W-1:0] DP_FIRE_THRESH = 17'h01E00;  // +30.0, applied inside the datapath

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/izh_state_ram.sv
// Per-neuron v/u register file: one async read port, one write port shared
// between datapath writeback and external configuration.
module izh_state_ram
  import izh_pkg::*;
#(
  parameter int             N_NEURONS = 16,
  parameter int             AW        = 4,
  parameter int             W         = DP_W,
  parameter logic [W-1:0]   RESET_V   = DP_RESET_V,
  parameter logic [W-1:0]   RESET_U   = DP_RESET_U
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_idx,
  output logic [W-1:0]  o_rd_v,
  output logic [W-1:0]  o_rd_u,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_idx,
  input  logic [W-1:0]  i_wb_v,
  input  logic [W-1:0]  i_wb_u,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_idx,
  input  logic [W-1:0]  i_cfg_v,
  input  logic [W-1:0]  i_cfg_u
);

  logic [W-1:0]  r_v [N_NEURONS];
  logic [W-1:0]  r_u [N_NEURONS];

  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [W-1:0]  w_v;
  logic [W-1:0]  w_u;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    w_we  = 1'b0;
    w_idx = '0;
    w_v   = '0;
    w_u   = '0;
    if (i_wb_we) begin
      w_we  = 1'b1;
      w_idx = i_wb_idx;
      w_v   = i_wb_v;
      w_u   = i_wb_u;
    end else if (i_cfg_we) begin
      w_we  = 1'b1;
      w_idx = i_cfg_idx;
      w_v   = i_cfg_v;
      w_u   = i_cfg_u;
    end
  end

  // NOTE: this state array is built from flops rather than a RAM macro, so it
  // can and must take the async reset; a true SRAM would need an init sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k] <= RESET_V;
        r_u[k] <= RESET_U;
      end
    end else if (w_we) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        if (w_idx == AW'(k)) begin
          r_v[k] <= w_v;
          r_u[k] <= w_u;
        end
      end
    end
  end

  assign o_rd_v = r_v[i_rd_idx];
  assign o_rd_u = r_u[i_rd_idx];

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one external Izhikevich datapath over N_NEURONS neurons,
// one timestep per start pulse, three cycles (FETCH/ISSUE/CAPTURE) per neuron.
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int           N_NEURONS = 16,
  parameter int           AW        = 4,
  parameter int           W         = DP_W,
  parameter logic [W-1:0] RESET_V   = DP_RESET_V,
  parameter logic [W-1:0] RESET_U   = DP_RESET_U
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_addr,
  input  logic [W-1:0]  cur_data,
  output logic [W-1:0]  dp_v,
  output logic [W-1:0]  dp_u,
  output logic [W-1:0]  dp_i,
  input  logic [W-1:0]  dp_v_prime,
  input  logic [W-1:0]  dp_u_prime,
  input  logic          dp_fired,
  output logic          spike_valid,
  output logic [AW-1:0] spike_id,
  output logic [AW:0]   spike_count,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_v,
  input  logic [W-1:0]  cfg_u
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  sched_state_e  r_state;
  sched_state_e  w_state_nxt;

  logic [AW-1:0] r_idx;
  logic [W-1:0]  r_dp_v;
  logic [W-1:0]  r_dp_u;
  logic [W-1:0]  r_dp_i;
  logic          r_spike_valid;
  logic [AW-1:0] r_spike_id;
  logic [AW:0]   r_spike_count;

  logic          w_busy;
  logic          w_done;
  logic          w_accept;
  logic          w_issue;
  logic          w_capture;
  logic          w_last;
  logic          w_cfg_we;
  logic [W-1:0]  w_rd_v;
  logic [W-1:0]  w_rd_u;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_cfg_we = cfg_we & ~w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:   w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The last neuron leaves idx at N_NEURONS-1; the next accepted start rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if (w_capture && !w_last) begin
      r_idx <= r_idx + AW'(1);
    end
  end

  // Operand holding registers: the datapath is free-running, so its inputs
  // stay frozen outside ISSUE instead of following the read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_v <= '0;
      r_dp_u <= '0;
      r_dp_i <= '0;
    end else if (w_issue) begin
      r_dp_v <= w_rd_v;
      r_dp_u <= w_rd_u;
      r_dp_i <= cur_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_spike_count <= '0;
    end else begin
      r_spike_valid <= w_capture & dp_fired;
      if (w_capture && dp_fired) begin
        r_spike_id    <= r_idx;
        r_spike_count <= r_spike_count + (AW+1)'(1);
      end else if (w_accept) begin
        r_spike_count <= '0;
      end
    end
  end

  izh_state_ram #(
    .N_NEURONS (N_NEURONS),
    .AW        (AW),
    .W         (W),
    .RESET_V   (RESET_V),
    .RESET_U   (RESET_U)
  ) u_state_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_idx  (r_idx),
    .o_rd_v    (w_rd_v),
    .o_rd_u    (w_rd_u),
    .i_wb_we   (w_capture),
    .i_wb_idx  (r_idx),
    .i_wb_v    (dp_v_prime),
    .i_wb_u    (dp_u_prime),
    .i_cfg_we  (w_cfg_we),
    .i_cfg_idx (cfg_addr),
    .i_cfg_v   (cfg_v),
    .i_cfg_u   (cfg_u)
  );

  assign busy        = w_busy;
  assign done        = w_done;
  assign cur_addr    = r_idx;
  assign dp_v        = w_issue ? w_rd_v   : r_dp_v;
  assign dp_u        = w_issue ? w_rd_u   : r_dp_u;
  assign dp_i        = w_issue ? cur_data : r_dp_i;
  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign spike_count = r_spike_count;

endmodule
